// File: rtl/rij_pkg.sv
// rij_pkg: shared constants for the IF/ID stage.
//   Holds the MIPS opcodes the hazard logic cares about, the NOP encoding,
//   the register-address width, the IF/ID FSM state type, and a helper
//   that says whether an opcode reads its rt field.
package rij_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam int          REG_AW   = 5;

  typedef enum logic {RUN, HOLD} state_t;

  // R-type, stores and compare-branches read rt as a source operand.
  // Every other format uses rt as a destination or not at all.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch-side, EX-side and decode-side signals of the IF/ID stage.
//   slave  : the IF/ID stage itself (takes fetch/EX inputs, drives id_* and stall).
//   master : the environment (fetch, ID/EX) driving the inputs.
//   Fetch side : if_ir, if_pc, if_npc, cond
//   EX side    : ex_mem_read, ex_rt
//   Decode side: id_ir, id_pc, id_npc, id_valid, id_rs, id_rt, bubble
//   Control    : stall (to fetch), stall_cnt (perf counter)
interface if_id_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] if_ir;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_npc;
  logic              cond;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic [DATA_W-1:0] id_ir;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_npc;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  if_ir, if_pc, if_npc, cond, ex_mem_read, ex_rt,
    output id_ir, id_pc, id_npc, id_valid, id_rs, id_rt, stall, bubble, stall_cnt
  );

  modport master (
    output if_ir, if_pc, if_npc, cond, ex_mem_read, ex_rt,
    input  id_ir, id_pc, id_npc, id_valid, id_rs, id_rt, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// hazard_detect: combinational load-use hazard check.
//   id_ir       in  instruction currently held in IF/ID
//   id_valid    in  id_ir is a real instruction
//   ex_mem_read in  instruction in ID/EX is a load
//   ex_rt       in  destination register of that load
//   hz          out decode would read the load result before it exists
module hazard_detect #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [DATA_W-1:0] id_ir,
  input  logic              id_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hz
);
  import rij_pkg::*;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt;
  logic              unused_lo;

  assign op = id_ir[31:26];
  assign rs = id_ir[21 +: REG_AW];
  assign rt = id_ir[16 +: REG_AW];
  // Immediate / funct bits play no part in the hazard decision.
  assign unused_lo = &{1'b0, id_ir[15:0]};

  // $zero is never a real dependency, even if a load targets it.
  assign hz = id_valid && ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == rs) || (uses_rt(op) && (ex_rt == rt)));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use hazard detection.
//   clk : pipeline clock, rising edge
//   rst : asynchronous active-high reset
//   bus : if_id_stage_if.slave (fetch inputs, EX load info, ID outputs,
//         stall to fetch, bubble to ID/EX, stall_cnt perf counter)
// Update priority at each edge: flush (cond) > stall > load.
module if_id_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst,
  if_id_stage_if.slave  bus
);
  import rij_pkg::*;

  logic [DATA_W-1:0] ir_q, pc_q, npc_q;
  logic              vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hz, stall;
  state_t            state, state_n;

  hazard_detect #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_hz (
    .id_ir       (ir_q),
    .id_valid    (vld_q),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .hz          (hz)
  );

  // HOLD lasts exactly one cycle after a stall, so a load that is still
  // visible in ID/EX next cycle cannot re-stall the same instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      RUN: if (hz && !bus.cond) begin
        state_n = HOLD;
        stall   = 1'b1;
      end
      HOLD: state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q  <= NOP_INST[DATA_W-1:0];
      pc_q  <= '0;
      npc_q <= '0;
      vld_q <= 1'b0;
    end else if (bus.cond) begin
      // Flushed slot keeps its PC so downstream sees where the NOP came from.
      ir_q  <= NOP_INST[DATA_W-1:0];
      pc_q  <= bus.if_pc;
      npc_q <= bus.if_npc;
      vld_q <= 1'b0;
    end else if (!stall) begin
      ir_q  <= bus.if_ir;
      pc_q  <= bus.if_pc;
      npc_q <= bus.if_npc;
      vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.id_ir     = ir_q;
  assign bus.id_pc     = pc_q;
  assign bus.id_npc    = npc_q;
  assign bus.id_valid  = vld_q;
  assign bus.id_rs     = ir_q[21 +: REG_AW];
  assign bus.id_rt     = ir_q[16 +: REG_AW];
  assign bus.stall     = stall;
  assign bus.bubble    = stall;
  assign bus.stall_cnt = cnt_q;
endmodule
